lsu: RTL and testbench

Load/store unit: the initiator side of the core's word-addressed data-memory port. It accepts one byte, halfword or word load/store request from the execute stage, then drives aligned word addresses, byte strobes and write lanes toward the data RAM. It captures the RAM's combinational read data, sign- or zero-extends it, and returns one response per request. It sits between the pipeline's memory stage and the data RAM instance.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_if.sv | 42 ++++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu.sv | 186 ++++++++++++++++++
 tb/tb_lsu.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM state codes,
// the latched request payload and the size-to-byte-mask helper.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [3:0] size_to_mask(size_e s);
    case (s)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundles around the load/store unit.
//   lsu_req_if : execute-stage request and one-pulse response (master = pipeline, slave = lsu)
//   lsu_mem_if : word-addressed data-RAM port (master = lsu, slave = RAM)
interface lsu_req_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_re_o;

  modport master (
    output mem_addr_o, mem_data_o, mem_we_o, mem_wstrb_o, mem_re_o,
    input  mem_data_i
  );
  modport slave (
    input  mem_addr_o, mem_data_o, mem_we_o, mem_wstrb_o, mem_re_o,
    output mem_data_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports: size_i/uns_i/off_i describe the access, wdata_i is right-justified store
// data, lo_i/hi_i are the first/second read words. wstrb_o/wlane_o are the 8-byte
// strobe and data windows (low half = first word, high half = second word);
// rdata_o is the extracted and extended load result.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wlane_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [31:0] merged;

  assign sh      = {off_i, 3'b000};
  assign wstrb_o = {4'b0000, size_to_mask(size_i)} << off_i;
  assign wlane_o = {32'h0, wdata_i} << sh;
  assign merged  = 32'({hi_i, lo_i} >> sh);

  // Truncate to the access size, then sign- or zero-extend.
  always_comb begin
    case (size_i)
      SZ_BYTE: rdata_o = {{24{~uns_i & merged[7]}}, merged[7:0]};
      SZ_HALF: rdata_o = {{16{~uns_i & merged[15]}}, merged[15:0]};
      default: rdata_o = merged;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, performs one or two aligned
// word accesses on the data-RAM port and returns a single response pulse.
// Ports: clk, rst (sync, active-high), req (lsu_req_if.slave: request/response),
// mem (lsu_mem_if.master: RAM address, strobes, write data, read data).
// Build option: define LSU_MISALIGNED_EN to allow unaligned accesses, which split
// into two word accesses when they cross a word boundary; otherwise they are
// rejected with an error response.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  localparam logic [31:0] ADDR_MASK = 32'((64'd1 << (DEPTH + 2)) - 64'd1) & 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  req_t        op_q, op_d, in_op, cur_op;
  logic [31:0] lo_q, lo_d, hi_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [7:0]  wstrb8;
  logic [63:0] wlane;
  logic [31:0] ext_rdata, acc1_addr;
  logic        legal, split;

  assign in_op = '{we: req.req_we_i, size: size_e'(req.req_size_i), uns: req.req_unsigned_i,
                   addr: req.req_addr_i, wdata: req.req_wdata_i};
  // Lane logic looks at the incoming request in IDLE, at the latched one afterwards.
  assign cur_op    = (state_q == S_IDLE) ? in_op : op_q;
  assign acc1_addr = ({op_q.addr[31:2], 2'b00} + 32'd4) & ADDR_MASK;

`ifdef LSU_MISALIGNED_EN
  logic [31:0] hi_q;

  assign legal = (in_op.size != SZ_RSVD);
  assign split = |wstrb8[7:4];

  // Second read word; cleared on every first access so single accesses see zero.
  always_comb begin
    hi_d = hi_q;
    if (state_q == S_ACC0) hi_d = '0;
    else if (state_q == S_ACC1 && !op_q.we) hi_d = mem.mem_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end
`else
  always_comb begin
    case (in_op.size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~in_op.addr[0];
      SZ_WORD: legal = (in_op.addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end
  assign split = 1'b0;
  assign hi_d  = '0;
`endif

  assign lo_d = (state_q == S_ACC0 && !op_q.we) ? mem.mem_data_i : lo_q;

  lsu_align u_align (
    .size_i  (cur_op.size),
    .uns_i   (cur_op.uns),
    .off_i   (cur_op.addr[1:0]),
    .wdata_i (cur_op.wdata),
    .lo_i    (lo_d),
    .hi_i    (hi_d),
    .wstrb_o (wstrb8),
    .wlane_o (wlane),
    .rdata_o (ext_rdata)
  );

  // Next state plus the registered values of every output for the next cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_addr_d  = '0;
    mem_data_d  = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_wstrb_d = '0;
    case (state_q)
      S_IDLE: begin
        if (req.req_valid_i && ready_q) begin
          op_d = in_op;
          if (!legal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = S_ACC0;
            mem_addr_d = {in_op.addr[31:2], 2'b00} & ADDR_MASK;
            mem_we_d   = in_op.we;
            mem_re_d   = ~in_op.we;
            if (in_op.we) begin
              mem_wstrb_d = wstrb8[3:0];
              mem_data_d  = wlane[31:0];
            end
          end
        end
      end
      S_ACC0: begin
        if (split) begin
          state_d    = S_ACC1;
          mem_addr_d = acc1_addr;
          mem_we_d   = op_q.we;
          mem_re_d   = ~op_q.we;
          if (op_q.we) begin
            mem_wstrb_d = wstrb8[7:4];
            mem_data_d  = wlane[63:32];
          end
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = op_q.we ? '0 : ext_rdata;
        end
      end
      S_ACC1: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = op_q.we ? '0 : ext_rdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      lo_q        <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Reset masks the handshake and access strobes at once, so a reset raised
  // mid-access keeps that cycle's write from committing.
  assign req.req_ready_o = ready_q & ~rst;
  assign req.rsp_valid_o = rsp_valid_q;
  assign req.rsp_err_o   = rsp_err_q;
  assign req.rsp_rdata_o = rsp_rdata_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_data_o  = mem_data_q;
  assign mem.mem_we_o    = mem_we_q & ~rst;
  assign mem.mem_re_o    = mem_re_q & ~rst;
  assign mem.mem_wstrb_o = mem_wstrb_q & {4{~rst}};

endmodule

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
module tb_lsu;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   re_cnt = 0;
  int   we_cnt = 0;
  int   next_id = 0;
  exp_t sbq[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_strb[$];
  logic [31:0] wq_data[$];
  logic [31:0] ram [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_req_if rq ();
  lsu_mem_if mi ();

  lsu #(.DEPTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .req (rq),
    .mem (mi)
  );

  // Data RAM model: combinational read, byte-strobed write on the rising edge.
  assign mi.mem_data_i = ram[mi.mem_addr_o[11:2]];
  always @(posedge clk) begin
    if (mi.mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mi.mem_wstrb_o[b]) ram[mi.mem_addr_o[11:2]][8*b +: 8] = mi.mem_data_o[8*b +: 8];
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: bus activity log plus scoreboard comparison of every response pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mi.mem_re_o || mi.mem_we_o)
      check("re_we_exclusive", 32'(mi.mem_re_o & mi.mem_we_o), 32'd0);
    if (mi.mem_re_o) re_cnt++;
    if (mi.mem_we_o) begin
      we_cnt++;
      wq_addr.push_back(mi.mem_addr_o);
      wq_strb.push_back(32'(mi.mem_wstrb_o));
      wq_data.push_back(mi.mem_data_o);
    end
    if (rq.rsp_valid_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h err %0d expected no response",
                 rq.rsp_rdata_o, rq.rsp_err_o);
      end else begin
        e = sbq.pop_front();
        check($sformatf("rsp_rdata#%0d", e.id), rq.rsp_rdata_o, e.rdata);
        check($sformatf("rsp_err#%0d", e.id), 32'(rq.rsp_err_o), 32'(e.err));
        check($sformatf("rsp_latency#%0d", e.id), 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic push,
                       input logic [31:0] er, input logic ee, input int lat);
    int n = 0;
    @(negedge clk);
    rq.req_valid_i    = 1'b1;
    rq.req_we_i       = we;
    rq.req_size_i     = sz;
    rq.req_unsigned_i = uns;
    rq.req_addr_i     = a;
    rq.req_wdata_i    = wd;
    while (rq.req_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready %b expected 1 within 50 cycles", rq.req_ready_o);
      rq.req_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rq.req_valid_i = 1'b0;
      if (push) sbq.push_back('{rdata: er, err: ee, lat: lat, acc: cyc, id: next_id});
      next_id++;
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                    input logic [31:0] er, input logic ee, input int lat);
    issue(1'b0, sz, uns, a, 32'h0, 1'b1, er, ee, lat);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                    input logic ee, input int lat);
    issue(1'b1, sz, 1'b0, a, wd, 1'b1, 32'h0, ee, lat);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d responses outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_strb.delete();
    wq_data.delete();
    re_cnt = 0;
    we_cnt = 0;
  endtask

  task automatic check_write(string name, logic [31:0] a, logic [31:0] s, logic [31:0] d);
    if (wq_addr.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no write expected addr %h", name, a);
    end else begin
      check({name, "_addr"}, wq_addr[0], a);
      check({name, "_strb"}, wq_strb[0], s);
      check({name, "_data"}, wq_data[0], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rq.req_valid_i    = 1'b0;
    rq.req_we_i       = 1'b0;
    rq.req_size_i     = 2'b00;
    rq.req_unsigned_i = 1'b0;
    rq.req_addr_i     = 32'h0;
    rq.req_wdata_i    = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_ready",     32'(rq.req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rq.rsp_valid_o), 32'd0);
    check("rst_rsp_err",   32'(rq.rsp_err_o),   32'd0);
    check("rst_rsp_rdata", rq.rsp_rdata_o,      32'd0);
    check("rst_mem_ctrl",  32'({mi.mem_re_o, mi.mem_we_o, mi.mem_wstrb_o}), 32'd0);
    check("rst_mem_addr",  mi.mem_addr_o,       32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_rst", 32'(rq.req_ready_o), 32'd1);

    // Aligned word store, then read back.
    clear_log();
    st(W, 32'h40, 32'hDEAD_BEEF, 1'b0, 2);
    wait_done();
    check_write("st_word", 32'h40, 32'hF, 32'hDEAD_BEEF);
    ld(W, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 2);
    wait_done();

    // Byte loads with sign and zero extension.
    ram[16] = 32'h80FF_FF7F;
    ld(B, 1'b0, 32'h43, 32'hFFFF_FF80, 1'b0, 2);
    ld(B, 1'b1, 32'h43, 32'h0000_0080, 1'b0, 2);
    ld(B, 1'b0, 32'h40, 32'h0000_007F, 1'b0, 2);
    wait_done();

    // Halfword store into the upper lanes, then signed read back.
    clear_log();
    st(H, 32'h12, 32'h0000_A5B6, 1'b0, 2);
    wait_done();
    check_write("st_half", 32'h10, 32'hC, 32'hA5B6_0000);
    ld(H, 1'b0, 32'h12, 32'hFFFF_A5B6, 1'b0, 2);
    ld(H, 1'b1, 32'h12, 32'h0000_A5B6, 1'b0, 2);
    wait_done();

    // Word load crossing a word boundary.
    ram[16] = 32'h4433_2211;
    ram[17] = 32'h8877_6655;
    clear_log();
`ifdef LSU_MISALIGNED_EN
    ld(W, 1'b0, 32'h41, 32'h5544_3322, 1'b0, 3);
    wait_done();
    check("split_ld_reads", 32'(re_cnt), 32'd2);
`else
    ld(W, 1'b0, 32'h41, 32'h0, 1'b1, 1);
    wait_done();
    check("misalign_ld_reads", 32'(re_cnt), 32'd0);
`endif

    // Reserved size: error, no memory access.
    clear_log();
    ld(R, 1'b0, 32'h40, 32'h0, 1'b1, 1);
    st(R, 32'h40, 32'hFFFF_FFFF, 1'b1, 1);
    wait_done();
    check("rsvd_reads",  32'(re_cnt), 32'd0);
    check("rsvd_writes", 32'(we_cnt), 32'd0);
    check("rsvd_ram",    ram[16],     32'h4433_2211);

    // Top-lane byte store then word read.
    clear_log();
    st(B, 32'h47, 32'h0000_005A, 1'b0, 2);
    wait_done();
    check_write("st_byte", 32'h44, 32'h8, 32'h5A00_0000);
    ld(W, 1'b0, 32'h44, 32'h5A77_6655, 1'b0, 2);
    wait_done();

    // Halfword at offset 3.
`ifdef LSU_MISALIGNED_EN
    ld(H, 1'b0, 32'h13, 32'h0000_00A5, 1'b0, 3);
`else
    ld(H, 1'b0, 32'h13, 32'h0, 1'b1, 1);
`endif
    wait_done();

    // Reset in the middle of a store: no response, partial commit only.
    clear_log();
`ifdef LSU_MISALIGNED_EN
    issue(1'b1, W, 1'b0, 32'h42, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
`else
    issue(1'b1, W, 1'b0, 32'h40, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(rq.req_ready_o), 32'd0);
    check("midrst_we",    32'(mi.mem_we_o),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_ready_after", 32'(rq.req_ready_o), 32'd1);
    repeat (3) @(negedge clk);
`ifdef LSU_MISALIGNED_EN
    check("midrst_writes",  32'(we_cnt), 32'd1);
    check("midrst_ram_lo",  ram[16],     32'h3344_2211);
`else
    check("midrst_writes",  32'(we_cnt), 32'd0);
    check("midrst_ram_lo",  ram[16],     32'h4433_2211);
`endif
    check("midrst_ram_hi",  ram[17],     32'h5A77_6655);

    // Unit still works after the mid-operation reset.
`ifdef LSU_MISALIGNED_EN
    ld(W, 1'b0, 32'h40, 32'h3344_2211, 1'b0, 2);
`else
    ld(W, 1'b0, 32'h40, 32'h4433_2211, 1'b0, 2);
`endif
    wait_done();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
